// File: rtl/cla_seq_add_ctrl_if.sv
// Requester-side bus for the sequential nibble adder.
// Optional signed-overflow flag is present only when CLA_SEQ_ADD_OVF_EN is defined.
interface cla_seq_add_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_SEQ_ADD_OVF_EN
    logic             ovf;

    modport master (
        output start, sub, op_a, op_b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, op_a, op_b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, sub, op_a, op_b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, sub, op_a, op_b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/cla_seq_add_ctrl.sv
// Sequential WIDTH-bit add/subtract built from one shared 4-bit carry-lookahead
// slice, one nibble per clock (LSB first) with a registered inter-nibble carry.
// Optional feature macro: CLA_SEQ_ADD_OVF_EN (adds signed-overflow output ovf).
module cla_seq_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    cla_seq_add_ctrl_if.slave  bus
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SH_W   = IDX_W + 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

    // Reject widths that cannot be split into whole nibbles
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
        $error("cla_seq_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q,     a_nxt;
    logic [WIDTH-1:0] b_q,     b_nxt;
    logic             carry_q, carry_nxt;
    logic [IDX_W-1:0] idx_q,   idx_nxt;
    logic [WIDTH-1:0] sum_q,   sum_nxt;
    logic             cout_q,  cout_nxt;
    logic             busy_q,  busy_nxt;
    logic             done_q,  done_nxt;
`ifdef CLA_SEQ_ADD_OVF_EN
    logic             ovf_q,   ovf_nxt;
`endif

    logic [SH_W-1:0]  nib_sh;
    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_g;
    logic [3:0]       sl_p;
    logic [4:0]       sl_c;
    logic [3:0]       sl_s;

    // Shared 4-bit carry-lookahead slice fed by the nibble selected by idx_q
    always_comb begin
        nib_sh  = {idx_q, 2'b00};
        sl_a    = 4'(a_q >> nib_sh);
        sl_b    = 4'(b_q >> nib_sh);
        sl_g    = sl_a & sl_b;
        sl_p    = sl_a ^ sl_b;
        sl_c[0] = carry_q;
        sl_c[1] = sl_g[0] | (sl_p[0] & carry_q);
        sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & carry_q);
        sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
        sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
        sl_s    = sl_p ^ sl_c[3:0];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next-state: accept only in IDLE, leave RUN after the top nibble
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs and datapath next values; results hold outside accept/RUN
    always_comb begin
        a_nxt     = a_q;
        b_nxt     = b_q;
        carry_nxt = carry_q;
        idx_nxt   = idx_q;
        sum_nxt   = sum_q;
        cout_nxt  = cout_q;
`ifdef CLA_SEQ_ADD_OVF_EN
        ovf_nxt   = ovf_q;
`endif
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state_nxt == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_nxt     = bus.op_a;
                    b_nxt     = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_nxt = bus.sub | bus.cin;
                    idx_nxt   = '0;
                    sum_nxt   = '0;
                    cout_nxt  = 1'b0;
`ifdef CLA_SEQ_ADD_OVF_EN
                    ovf_nxt   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                sum_nxt   = (sum_q & ~(NIB_MASK << nib_sh)) | (WIDTH'(sl_s) << nib_sh);
                carry_nxt = sl_c[4];
                idx_nxt   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_nxt  = '0;
                    cout_nxt = sl_c[4];
`ifdef CLA_SEQ_ADD_OVF_EN
                    // carry into MSB xor carry out of MSB
                    ovf_nxt  = sl_c[3] ^ sl_c[4];
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CLA_SEQ_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            carry_q <= carry_nxt;
            idx_q   <= idx_nxt;
            sum_q   <= sum_nxt;
            cout_q  <= cout_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
`ifdef CLA_SEQ_ADD_OVF_EN
            ovf_q   <= ovf_nxt;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef CLA_SEQ_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Self-checking bench for cla_seq_add_ctrl (WIDTH=16) against an arithmetic reference.
module tb_cla_seq_add_ctrl;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int          BOUND  = 4 * NSLICE + 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    cla_seq_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular/signed arithmetic
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic c, output logic [15:0] r, output logic co,
                         output logic ov);
        logic [16:0] t;
        int          sa;
        int          sb;
        int          sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            r  = a - b;
            co = (a >= b);
            sr = sa - sb;
        end else begin
            t  = 17'(a) + 17'(b) + 17'(c);
            r  = t[15:0];
            co = t[16];
            sr = sa + sb + int'(c);
        end
        ov = (sr > 32767) || (sr < -32768);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while ((bus.done !== 1'b1) && (n < BOUND)) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic c, input string tag);
        logic [15:0] er;
        logic        eco;
        logic        eov;
        int          n;
        model(a, b, s, c, er, eco, eov);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.cin   = c;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.op_a  = 16'($urandom);
        bus.op_b  = 16'($urandom);
        bus.sub   = 1'($urandom);
        bus.cin   = 1'($urandom);
        check({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        check({tag, ".latency"}, 32'(n), 32'(NSLICE));
        check({tag, ".sum"}, 32'(bus.sum), 32'(er));
        check({tag, ".cout"}, 32'(bus.cout), 32'(eco));
`ifdef CLA_SEQ_ADD_OVF_EN
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(eov));
`endif
        check({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
        tick();
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".sum_hold"}, 32'(bus.sum), 32'(er));
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] sp [6];
        sp[0] = 16'h0000; sp[1] = 16'hFFFF; sp[2] = 16'h7FFF;
        sp[3] = 16'h8000; sp[4] = 16'h0001; sp[5] = 16'h000F;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        logic        busy_log [1:9];
        logic        done_log [1:9];
        logic [15:0] sum_at_done;
        logic [15:0] er;
        logic        eco;
        logic        eov;
        int          dcount;
        int          n;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
        tick();
        tick();
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.sum", 32'(bus.sum), 32'd0);
        check("reset.cout", 32'(bus.cout), 32'd0);
`ifdef CLA_SEQ_ADD_OVF_EN
        check("reset.ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();
        check("idle.busy", 32'(bus.busy), 32'd0);

        // Directed cases
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "basic_add");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple_b1");
        run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, "ripple_cin");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
        run_op(16'h0009, 16'h0003, 1'b1, 1'b0, "sub_noborrow");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_pos");
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, "ovf_neg");
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "ovf_none");

        // Result holds through idle cycles
        repeat (3) tick();
        check("hold.sum", 32'(bus.sum), 32'h0002);
        check("hold.cout", 32'(bus.cout), 32'd0);
        check("hold.done", 32'(bus.done), 32'd0);

        // start held high for 10 edges, operands change during RUN
        bus.op_a  = 16'h0001;
        bus.op_b  = 16'h0001;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.op_a    = 16'h1111;
        bus.op_b    = 16'h1111;
        dcount      = 0;
        sum_at_done = '0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            busy_log[i] = bus.busy;
            done_log[i] = bus.done;
            if (bus.done === 1'b1) begin
                dcount++;
                sum_at_done = bus.sum;
            end
        end
        bus.start = 1'b0;
        check("hold_start.done_count", 32'(dcount), 32'd1);
        check("hold_start.done_at4", 32'(done_log[4]), 32'd1);
        check("hold_start.sum", 32'(sum_at_done), 32'h0002);
        check("hold_start.idle_gap", 32'(busy_log[5]), 32'd0);
        check("hold_start.reaccept", 32'(busy_log[6]), 32'd1);
        wait_done(n);
        model(16'h1111, 16'h1111, 1'b0, 1'b0, er, eco, eov);
        check("hold_start.second_seen", 32'(n < BOUND), 32'd1);
        check("hold_start.second_sum", 32'(bus.sum), 32'(er));
        tick();

        // Reset two edges after accept aborts the operation
        bus.op_a  = 16'h00FF;
        bus.op_b  = 16'h0001;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check("abort.sum", 32'(bus.sum), 32'd0);
        check("abort.cout", 32'(bus.cout), 32'd0);
        dcount = 0;
        repeat (8) begin
            tick();
            if (bus.done === 1'b1) dcount++;
        end
        check("abort.no_done", 32'(dcount), 32'd0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, "after_abort");

        // Randomised operations
        for (int k = 0; k < 24; k++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
